// File: rtl/fir_pkg.sv
// Shared FIR datapath definitions: default operand width and the serial
// subtractor state encoding.
package fir_pkg;

    localparam int FIR_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } sub_state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor built from two half-subtractor cells and an OR.
module full_subtractor_bit (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    half_subtractor u_hs_xy (
        .i_x    (i_x),
        .i_y    (i_y),
        .o_d    (w_d1),
        .o_bout (w_b1)
    );

    half_subtractor u_hs_bin (
        .i_x    (w_d1),
        .i_y    (i_bin),
        .o_d    (o_d),
        .o_bout (w_b2)
    );

    assign o_bout = w_b1 | w_b2;

endmodule

// File: rtl/half_subtractor.sv
// Half-subtractor cell: d = x - y, bout set when x < y.
module half_subtractor (
    input  logic i_x,
    input  logic i_y,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_x ^ i_y;
    assign o_bout = ~i_x & i_y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock LSB-first, registered
// borrow chain, parallel load and a valid/ready result handshake.
module serial_subtractor
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Producers hold data while valid is high and ready low; every output
    // here is registered, so ready never depends on valid combinationally.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);

    sub_state_e       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_bf;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    full_subtractor_bit u_fsb (
        .i_x    (r_sa[0]),
        .i_y    (r_sb[0]),
        .i_bin  (r_bf),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // The final bit completes the word; the partial register only ever
    // needs WIDTH-1 bits because the last bit lands straight in the shadow.
    assign w_res_next = {w_d, r_res};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_bf        <= 1'b0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sa       <= a;
                        r_sb       <= b;
                        r_bf       <= 1'b0;
                        r_cnt      <= '0;
                        r_res      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_bf  <= w_bout;
                    r_res <= w_res_next[WIDTH-1:1];
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_diff      <= w_res_next;
                        r_borrow    <= w_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign diff        = r_diff;
    assign borrow      = r_borrow;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the scenario
// tests and a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;
    import fir_pkg::*;

    logic       clk;
    logic       rst_n;

    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] diff8;
    logic       borrow8;
    logic       busy8;
    logic [1:0] st8;

    logic       in_valid4;
    logic       in_ready4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       out_valid4;
    logic       out_ready4;
    logic [3:0] diff4;
    logic       borrow4;
    logic       busy4;
    logic [1:0] st4;

    int n_checks;
    int n_fail;

    logic [4:0] exp_q[$];

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .diff        (diff8),
        .borrow      (borrow8),
        .busy        (busy8),
        .o_dbg_state (st8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .a           (a4),
        .b           (b4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .diff        (diff4),
        .borrow      (borrow4),
        .busy        (busy4),
        .o_dbg_state (st4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: wait for in_ready, present one operand pair for the accept
    // edge, then count edges until out_valid appears (50 means timeout).
    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
        int t;
        t = 0;
        while (!in_ready8 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        a8 = a;
        b8 = b;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || diff8 !== 8'd0 ||
            borrow8 !== 1'b0 || busy8 !== 1'b0 || st8 !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b diff=%0d brw=%b busy=%b st=%0d, want 1 0 0 0 0 0",
                     in_ready8, out_valid8, diff8, borrow8, busy8, st8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        out_ready8 = 1'b1;
        op8(8'd200, 8'd55, lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, want 8", lat);
        end
        n_checks++;
        if (diff8 !== 8'd145 || borrow8 !== 1'b0 || busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got diff=%0d brw=%b busy=%b rdy=%b, want 145 0 1 0",
                     diff8, borrow8, busy8, in_ready8);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || diff8 !== 8'd145) begin
            n_fail++;
            $display("FAIL basic_one_cycle: got vld=%b rdy=%b diff=%0d, want 0 1 145",
                     out_valid8, in_ready8, diff8);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vd [3];
        logic       vw [3];
        int lat;
        va[0] = 8'd5;   vb[0] = 8'd10;  vd[0] = 8'd251; vw[0] = 1'b1;
        va[1] = 8'd0;   vb[1] = 8'd255; vd[1] = 8'd1;   vw[1] = 1'b1;
        va[2] = 8'd0;   vb[2] = 8'd0;   vd[2] = 8'd0;   vw[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op8(va[i], vb[i], lat);
            n_checks++;
            if (lat !== 8 || diff8 !== vd[i] || borrow8 !== vw[i]) begin
                n_fail++;
                $display("FAIL vector_%0d: got lat=%0d diff=%0d brw=%b, want 8 %0d %b",
                         i, lat, diff8, borrow8, vd[i], vw[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready8 = 1'b0;
        op8(8'd100, 8'd1, lat);
        n_checks++;
        if (lat !== 8 || diff8 !== 8'd99 || borrow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d diff=%0d brw=%b, want 8 99 0", lat, diff8, borrow8);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid8 !== 1'b1 || diff8 !== 8'd99 || in_ready8 !== 1'b0 || st8 !== S_DONE) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b diff=%0d rdy=%b st=%0d, want 1 99 0 2",
                         i, out_valid8, diff8, in_ready8, st8);
            end
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || diff8 !== 8'd99) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b diff=%0d, want 0 1 99",
                     out_valid8, in_ready8, diff8);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        a8 = 8'd30;
        b8 = 8'd12;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd7;
        b8 = 8'd9;
        n_checks++;
        if (in_ready8 !== 1'b0 || st8 !== S_SHIFT) begin
            n_fail++;
            $display("FAIL ign_shift_state: got rdy=%b st=%0d, want 0 1", in_ready8, st8);
        end
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 8 || diff8 !== 8'd18 || borrow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_first: got lat=%0d diff=%0d brw=%b, want 8 18 0", lat, diff8, borrow8);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || st8 !== S_IDLE) begin
            n_fail++;
            $display("FAIL ign_idle: got rdy=%b vld=%b st=%0d, want 1 0 0", in_ready8, out_valid8, st8);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== 8 || diff8 !== 8'd254 || borrow8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_second: got lat=%0d diff=%0d brw=%b, want 8 254 1", lat, diff8, borrow8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        a8 = 8'd50;
        b8 = 8'd20;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || diff8 !== 8'd0 ||
            borrow8 !== 1'b0 || busy8 !== 1'b0 || st8 !== S_IDLE) begin
            n_fail++;
            $display("FAIL abort_reset: got rdy=%b vld=%b diff=%0d brw=%b busy=%b st=%0d, want 1 0 0 0 0 0",
                     in_ready8, out_valid8, diff8, borrow8, busy8, st8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid8 === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_valid: got %0d out_valid cycles busy=%b, want 0 0", seen, busy8);
        end
        op8(8'd9, 8'd4, lat);
        n_checks++;
        if (lat !== 8 || diff8 !== 8'd5 || borrow8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: got lat=%0d diff=%0d brw=%b, want 8 5 0", lat, diff8, borrow8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int idx;
        int done_cnt;
        int cyc;
        int last_acc;
        logic acc;
        logic [4:0] exp;
        logic [4:0] got;
        out_ready4 = 1'b1;
        idx = 0;
        done_cnt = 0;
        cyc = 0;
        last_acc = 0;
        a4 = 4'd0;
        b4 = 4'd0;
        in_valid4 = 1'b1;
        while (done_cnt < 256 && cyc < 4000) begin
            acc = in_valid4 & in_ready4;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                exp[4]   = (a4 < b4);
                exp[3:0] = a4 - b4;
                exp_q.push_back(exp);
                if (idx > 0) begin
                    n_checks++;
                    if (cyc - last_acc !== 6) begin
                        n_fail++;
                        $display("FAIL b2b_interval_%0d: got %0d, want 6", idx, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                idx++;
                if (idx < 256) begin
                    a4 = 4'(idx >> 4);
                    b4 = 4'(idx);
                end else begin
                    in_valid4 = 1'b0;
                end
            end
            if (out_valid4) begin
                got = {borrow4, diff4};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected: got brw=%b diff=%0d, want no result", borrow4, diff4);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result_%0d: got brw=%b diff=%0d, want brw=%b diff=%0d",
                                 done_cnt, got[4], got[3:0], exp[4], exp[3:0]);
                    end
                end
                done_cnt++;
            end
        end
        n_checks++;
        if (done_cnt !== 256 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results %0d pending, want 256 0", done_cnt, exp_q.size());
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        out_ready8 = 1'b1;
        in_valid4  = 1'b0;
        a4         = '0;
        b4         = '0;
        out_ready4 = 1'b1;
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
